// File: rtl/pixel_generator_pkg.sv
// Shared definitions for the pixel generator: default frame geometry,
// register-file size, AXI response code, state enums and the pixel
// assembly helper.
package pixel_generator_pkg;

  localparam int DEFAULT_X_SIZE = 200;
  localparam int DEFAULT_Y_SIZE = 200;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Position of a word inside its 3-word / 4-pixel packing group.
  typedef enum logic [1:0] {
    PH_WORD0,
    PH_WORD1,
    PH_WORD2
  } pack_phase_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_RESP
  } write_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACCEPT,
    RD_DATA
  } read_state_t;

  // A pixel is {R, G, B} with R from x, G from y, B from the blue register.
  function automatic logic [23:0] make_pixel(input logic [7:0] x,
                                             input logic [7:0] y,
                                             input logic [7:0] blue);
    return {x, y, blue};
  endfunction

endpackage

// File: rtl/pixel_generator_regs.sv
// AXI-Lite register block: eight 32-bit read/write registers selected by
// addr[4:2]. One outstanding transaction per channel; a new address is only
// accepted once the previous response has been taken.
//
// Ports:
//   clk, axi_reset         clock, synchronous active-high reset
//   awaddr/awvalid/awready write address channel
//   wdata/wvalid/wready    write data channel
//   bresp/bvalid/bready    write response channel
//   araddr/arvalid/arready read address channel
//   rdata/rresp/rvalid/rready read data channel
//   blue_value             low byte of register 0
module pixel_generator_regs
  import pixel_generator_pkg::*;
(
  input  logic        clk,
  input  logic        axi_reset,
  input  logic [7:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [7:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic [7:0]  blue_value
);

  write_state_t wr_state, wr_next;
  read_state_t  rd_state, rd_next;

  logic [31:0] regs [NUM_REGS];
  logic [31:0] rdata_q;
  logic        wr_fire;
  logic        rd_fire;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [REG_IDX_W-1:0] rd_idx;

  // Only addr[4:2] selects a register; the remaining bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[7:5], awaddr[1:0], araddr[7:5], araddr[1:0]};

  assign wr_idx  = awaddr[4:2];
  assign rd_idx  = araddr[4:2];
  assign wr_fire = (wr_state == WR_ACCEPT) && awvalid && wvalid;
  assign rd_fire = (rd_state == RD_ACCEPT) && arvalid;

  always_ff @(posedge clk) begin
    if (axi_reset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Ready is raised for one cycle after a request is seen, then the
  // response is held until taken.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:   if (awvalid && wvalid) wr_next = WR_ACCEPT;
      WR_ACCEPT: wr_next = (awvalid && wvalid) ? WR_RESP : WR_IDLE;
      WR_RESP:   if (bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:   if (arvalid) rd_next = RD_ACCEPT;
      RD_ACCEPT: rd_next = arvalid ? RD_DATA : RD_IDLE;
      RD_DATA:   if (rready) rd_next = RD_IDLE;
      default:   rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    awready = (wr_state == WR_ACCEPT);
    wready  = (wr_state == WR_ACCEPT);
    bvalid  = (wr_state == WR_RESP);
    bresp   = RESP_OKAY;
    arready = (rd_state == RD_ACCEPT);
    rvalid  = (rd_state == RD_DATA);
    rresp   = RESP_OKAY;
    rdata   = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (axi_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (axi_reset) begin
      rdata_q <= '0;
    end else if (rd_fire) begin
      rdata_q <= regs[rd_idx];
    end
  end

  assign blue_value = regs[0][7:0];

endmodule

// File: rtl/pixel_generator.sv
// Test-pattern video source: emits an AXI-Stream of 24-bit RGB pixels packed
// four pixels into three 32-bit words. R follows x, G follows y, B comes from
// register 0 of the AXI-Lite block, latched once per frame.
//
// Ports:
//   out_stream_aclk, axi_reset   clock, synchronous active-high reset
//   out_stream_*                 AXI-Stream master (tuser = SOF, tlast = EOL)
//   s_axi_lite_*                 AXI-Lite slave for the register block
module pixel_generator
  import pixel_generator_pkg::*;
#(
  parameter int X_SIZE = DEFAULT_X_SIZE,
  parameter int Y_SIZE = DEFAULT_Y_SIZE
) (
  input  logic        out_stream_aclk,
  input  logic        axi_reset,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid,
  output logic        out_stream_tuser,
  input  logic [7:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [7:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  localparam int WPL    = X_SIZE * 3 / 4;
  localparam int WORD_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LINE_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPL - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(Y_SIZE - 1);

  pack_phase_t phase, phase_next;

  logic [WORD_W-1:0] word_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [7:0]  x_base;
  logic [7:0]  line_y;
  logic [7:0]  frame_blue;
  logic [7:0]  blue_value;
  logic        valid_q;
  logic        xfer;
  logic        end_of_line;
  logic        end_of_frame;
  logic [23:0] p0, p1, p2, p3;
  logic [31:0] packed_word;

  pixel_generator_regs u_regs (
    .clk        (out_stream_aclk),
    .axi_reset  (axi_reset),
    .awaddr     (s_axi_lite_awaddr),
    .awvalid    (s_axi_lite_awvalid),
    .awready    (s_axi_lite_awready),
    .wdata      (s_axi_lite_wdata),
    .wvalid     (s_axi_lite_wvalid),
    .wready     (s_axi_lite_wready),
    .bresp      (s_axi_lite_bresp),
    .bvalid     (s_axi_lite_bvalid),
    .bready     (s_axi_lite_bready),
    .araddr     (s_axi_lite_araddr),
    .arvalid    (s_axi_lite_arvalid),
    .arready    (s_axi_lite_arready),
    .rdata      (s_axi_lite_rdata),
    .rresp      (s_axi_lite_rresp),
    .rvalid     (s_axi_lite_rvalid),
    .rready     (s_axi_lite_rready),
    .blue_value (blue_value)
  );

  assign xfer         = valid_q && out_stream_tready;
  assign end_of_line  = (word_cnt == LAST_WORD);
  assign end_of_frame = end_of_line && (line_cnt == LAST_LINE);
  assign line_y       = 8'(line_cnt);

  always_ff @(posedge out_stream_aclk) begin
    if (axi_reset) phase <= PH_WORD0;
    else           phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    if (xfer) begin
      if (end_of_line) begin
        phase_next = PH_WORD0;
      end else begin
        case (phase)
          PH_WORD0: phase_next = PH_WORD1;
          PH_WORD1: phase_next = PH_WORD2;
          default:  phase_next = PH_WORD0;
        endcase
      end
    end
  end

  // x_base is only the low byte of the group's first x: R carries x[7:0],
  // so wrapping modulo 256 gives the right colour on wide lines.
  assign p0 = make_pixel(x_base,         line_y, frame_blue);
  assign p1 = make_pixel(x_base + 8'd1,  line_y, frame_blue);
  assign p2 = make_pixel(x_base + 8'd2,  line_y, frame_blue);
  assign p3 = make_pixel(x_base + 8'd3,  line_y, frame_blue);

  always_comb begin
    packed_word = '0;
    case (phase)
      PH_WORD0: packed_word = {p1[7:0], p0};
      PH_WORD1: packed_word = {p2[15:0], p1[23:8]};
      PH_WORD2: packed_word = {p3, p2[23:16]};
      default:  packed_word = '0;
    endcase
  end

  // Blue is latched when the last word of a frame leaves, so it is fixed
  // from the first word of the next frame onward and cannot change mid-frame.
  always_ff @(posedge out_stream_aclk) begin
    if (axi_reset) begin
      valid_q    <= 1'b0;
      word_cnt   <= '0;
      line_cnt   <= '0;
      x_base     <= '0;
      frame_blue <= '0;
    end else begin
      valid_q <= 1'b1;
      if (xfer) begin
        if (end_of_line) begin
          word_cnt <= '0;
          x_base   <= '0;
          if (end_of_frame) begin
            line_cnt   <= '0;
            frame_blue <= blue_value;
          end else begin
            line_cnt <= line_cnt + 1'b1;
          end
        end else begin
          word_cnt <= word_cnt + 1'b1;
          if (phase == PH_WORD2) x_base <= x_base + 8'd4;
        end
      end
    end
  end

  assign out_stream_tvalid = valid_q;
  assign out_stream_tdata  = valid_q ? packed_word : 32'h0;
  assign out_stream_tuser  = valid_q && (word_cnt == '0) && (line_cnt == '0);
  assign out_stream_tlast  = valid_q && end_of_line;
  assign out_stream_tkeep  = 4'hF;

endmodule

// File: tb/tb_pixel_generator.sv
// Self-checking bench for pixel_generator: a reference model of the pixel
// stream checks every transferred word under steady, random and pulsed
// tready; table-driven AXI-Lite register writes/reads; hand sequences for
// held responses, address blocking and mid-frame reset.
module tb_pixel_generator;
  import pixel_generator_pkg::*;

  localparam int X_SIZE      = DEFAULT_X_SIZE;
  localparam int Y_SIZE      = DEFAULT_Y_SIZE;
  localparam int WPL         = X_SIZE * 3 / 4;
  localparam int FRAME_WORDS = WPL * Y_SIZE;

  logic        out_stream_aclk;
  logic        axi_reset;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tready;
  logic        out_stream_tvalid;
  logic        out_stream_tuser;
  logic [7:0]  s_axi_lite_awaddr;
  logic        s_axi_lite_awvalid;
  logic        s_axi_lite_awready;
  logic [31:0] s_axi_lite_wdata;
  logic        s_axi_lite_wvalid;
  logic        s_axi_lite_wready;
  logic [1:0]  s_axi_lite_bresp;
  logic        s_axi_lite_bvalid;
  logic        s_axi_lite_bready;
  logic [7:0]  s_axi_lite_araddr;
  logic        s_axi_lite_arvalid;
  logic        s_axi_lite_arready;
  logic [31:0] s_axi_lite_rdata;
  logic [1:0]  s_axi_lite_rresp;
  logic        s_axi_lite_rvalid;
  logic        s_axi_lite_rready;

  typedef struct {
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp_data;
  } reg_vec_t;

  reg_vec_t    reg_table [NUM_REGS];
  logic [31:0] reg_model [NUM_REGS];

  int vectors    = 0;
  int miscompares = 0;
  int ready_mode = 0;
  int pulse_cnt  = 0;

  // Reference model state
  int          m_word  = 0;
  int          m_line  = 0;
  int          m_total = 0;
  logic [7:0]  m_blue  = 8'h00;
  logic [7:0]  m_reg0  = 8'h00;

  logic [31:0] frame1_data = '0;
  logic        frame1_user = 1'b0;
  bit          frame1_seen = 0;
  logic        tlast149 = 1'b0;
  logic        tlast299 = 1'b0;
  bit          capture_after_reset = 0;
  bit          after_reset_seen = 0;
  logic [31:0] after_reset_data = '0;
  logic        after_reset_user = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_user  = 1'b0;
  logic        prev_last  = 1'b0;
  logic        rst_prev   = 1'b0;
  bit          valid_seen = 0;

  pixel_generator #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) dut (
    .out_stream_aclk    (out_stream_aclk),
    .axi_reset          (axi_reset),
    .out_stream_tdata   (out_stream_tdata),
    .out_stream_tkeep   (out_stream_tkeep),
    .out_stream_tlast   (out_stream_tlast),
    .out_stream_tready  (out_stream_tready),
    .out_stream_tvalid  (out_stream_tvalid),
    .out_stream_tuser   (out_stream_tuser),
    .s_axi_lite_awaddr  (s_axi_lite_awaddr),
    .s_axi_lite_awvalid (s_axi_lite_awvalid),
    .s_axi_lite_awready (s_axi_lite_awready),
    .s_axi_lite_wdata   (s_axi_lite_wdata),
    .s_axi_lite_wvalid  (s_axi_lite_wvalid),
    .s_axi_lite_wready  (s_axi_lite_wready),
    .s_axi_lite_bresp   (s_axi_lite_bresp),
    .s_axi_lite_bvalid  (s_axi_lite_bvalid),
    .s_axi_lite_bready  (s_axi_lite_bready),
    .s_axi_lite_araddr  (s_axi_lite_araddr),
    .s_axi_lite_arvalid (s_axi_lite_arvalid),
    .s_axi_lite_arready (s_axi_lite_arready),
    .s_axi_lite_rdata   (s_axi_lite_rdata),
    .s_axi_lite_rresp   (s_axi_lite_rresp),
    .s_axi_lite_rvalid  (s_axi_lite_rvalid),
    .s_axi_lite_rready  (s_axi_lite_rready)
  );

  initial begin
    out_stream_aclk = 1'b0;
    forever #5 out_stream_aclk = ~out_stream_aclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected stream word straight from the pixel/packing rules.
  function automatic logic [31:0] expWord(input int w, input int l, input logic [7:0] b);
    logic [23:0] p [4];
    int g;
    int x;
    g = w / 3;
    for (int i = 0; i < 4; i++) begin
      x = 4 * g + i;
      p[i] = {8'(x), 8'(l), b};
    end
    case (w % 3)
      0:       return {p[1][7:0], p[0]};
      1:       return {p[2][15:0], p[1][23:8]};
      default: return {p[3], p[2][23:16]};
    endcase
  endfunction

  // tready driver: 0 = always ready, 1 = random, 2 = one-in-three pulse
  initial begin
    out_stream_tready = 1'b0;
    forever begin
      @(posedge out_stream_aclk);
      #1;
      case (ready_mode)
        0:       out_stream_tready = 1'b1;
        1:       out_stream_tready = 1'($urandom_range(0, 1));
        2:       out_stream_tready = ((pulse_cnt % 3) == 2);
        default: out_stream_tready = 1'b0;
      endcase
      pulse_cnt++;
    end
  end

  // Stream monitor and reference model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge out_stream_aclk);
      if (axi_reset) begin
        if (rst_prev) begin
          checkOutput("tvalid in reset", out_stream_tvalid, 0);
          checkOutput("tdata in reset", out_stream_tdata, 0);
        end
        m_word = 0;
        m_line = 0;
        m_blue = 8'h00;
        m_reg0 = 8'h00;
        valid_seen = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall tvalid held", out_stream_tvalid, 1);
          checkOutput("stall tdata held", out_stream_tdata, prev_data);
          checkOutput("stall tuser held", out_stream_tuser, prev_user);
          checkOutput("stall tlast held", out_stream_tlast, prev_last);
        end
        if (valid_seen) checkOutput("tvalid continuous", out_stream_tvalid, 1);
        if (out_stream_tvalid) valid_seen = 1;
        if (out_stream_tvalid && out_stream_tready) begin
          checkOutput("word tdata", out_stream_tdata, expWord(m_word, m_line, m_blue));
          checkOutput("word tuser", out_stream_tuser, (m_word == 0 && m_line == 0));
          checkOutput("word tlast", out_stream_tlast, (m_word == WPL - 1));
          if (m_total == 149) tlast149 = out_stream_tlast;
          if (m_total == 299) tlast299 = out_stream_tlast;
          if (m_total == FRAME_WORDS) begin
            frame1_data = out_stream_tdata;
            frame1_user = out_stream_tuser;
            frame1_seen = 1;
          end
          if (capture_after_reset) begin
            after_reset_data = out_stream_tdata;
            after_reset_user = out_stream_tuser;
            after_reset_seen = 1;
            capture_after_reset = 0;
          end
          if (m_word == WPL - 1) begin
            m_word = 0;
            if (m_line == Y_SIZE - 1) begin
              m_line = 0;
              m_blue = m_reg0;
            end else begin
              m_line++;
            end
          end else begin
            m_word++;
          end
          m_total++;
        end
        prev_stall = out_stream_tvalid && !out_stream_tready;
        prev_data  = out_stream_tdata;
        prev_user  = out_stream_tuser;
        prev_last  = out_stream_tlast;
      end
      rst_prev = axi_reset;
    end
  end

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
    int n;
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_awaddr  = addr;
    s_axi_lite_awvalid = 1'b1;
    s_axi_lite_wdata   = data;
    s_axi_lite_wvalid  = 1'b1;
    s_axi_lite_bready  = 1'b1;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!(s_axi_lite_awready && s_axi_lite_wready) && n < 20);
    checkOutput("write accepted", s_axi_lite_awready && s_axi_lite_wready, 1);
    reg_model[addr[4:2]] = data;
    if (addr[4:2] == 3'd0) m_reg0 = data[7:0];
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wvalid  = 1'b0;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_bvalid && n < 20);
    checkOutput("bvalid", s_axi_lite_bvalid, 1);
    checkOutput("bresp", s_axi_lite_bresp, RESP_OKAY);
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_bready = 1'b0;
  endtask

  task automatic axiRead(input logic [7:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_araddr  = addr;
    s_axi_lite_arvalid = 1'b1;
    s_axi_lite_rready  = 1'b1;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_arready && n < 20);
    checkOutput("arready", s_axi_lite_arready, 1);
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_arvalid = 1'b0;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_rvalid && n < 20);
    checkOutput("rvalid", s_axi_lite_rvalid, 1);
    data = s_axi_lite_rdata;
    resp = s_axi_lite_rresp;
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_rready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    logic [1:0]  rr;

    axi_reset          = 1'b1;
    s_axi_lite_awaddr  = '0;
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wdata   = '0;
    s_axi_lite_wvalid  = 1'b0;
    s_axi_lite_bready  = 1'b0;
    s_axi_lite_araddr  = '0;
    s_axi_lite_arvalid = 1'b0;
    s_axi_lite_rready  = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) begin
      reg_table[i].waddr    = {3'($urandom_range(0, 7)), 3'(i), 2'($urandom_range(0, 3))};
      reg_table[i].raddr    = {3'($urandom_range(0, 7)), 3'(i), 2'($urandom_range(0, 3))};
      reg_table[i].wdata    = $urandom;
      reg_table[i].exp_data = reg_table[i].wdata;
    end

    repeat (4) @(posedge out_stream_aclk);
    @(negedge out_stream_aclk);
    checkOutput("reset tvalid", out_stream_tvalid, 0);
    checkOutput("reset tuser", out_stream_tuser, 0);
    checkOutput("reset tlast", out_stream_tlast, 0);
    checkOutput("reset tdata", out_stream_tdata, 0);
    checkOutput("reset tkeep", out_stream_tkeep, 4'hF);
    checkOutput("reset awready", s_axi_lite_awready, 0);
    checkOutput("reset wready", s_axi_lite_wready, 0);
    checkOutput("reset arready", s_axi_lite_arready, 0);
    checkOutput("reset bvalid", s_axi_lite_bvalid, 0);
    checkOutput("reset rvalid", s_axi_lite_rvalid, 0);

    @(posedge out_stream_aclk);
    #1 axi_reset = 1'b0;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!out_stream_tvalid && n < 16);
    checkOutput("tvalid after reset", out_stream_tvalid, 1);

    axiRead(8'h0C, rd, rr);
    checkOutput("REG3 reset value", rd, 0);

    for (int i = 0; i < NUM_REGS; i++) applyStimulus(reg_table[i].waddr, reg_table[i].wdata);
    for (int i = 0; i < NUM_REGS; i++) begin
      axiRead(reg_table[i].raddr, rd, rr);
      checkOutput("table readback", rd, reg_table[i].exp_data);
      checkOutput("table rresp", rr, RESP_OKAY);
    end

    // Held write response; a second request must wait behind it.
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_awaddr = 8'h04; s_axi_lite_wdata = 32'hA5A5_0001;
    s_axi_lite_awvalid = 1'b1; s_axi_lite_wvalid = 1'b1; s_axi_lite_bready = 1'b0;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_awready && n < 20);
    checkOutput("hold write accepted", s_axi_lite_awready, 1);
    reg_model[1] = 32'hA5A5_0001;
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_awaddr = 8'h08; s_axi_lite_wdata = 32'h5A5A_0002;
    for (int k = 0; k < 4; k++) begin
      @(negedge out_stream_aclk);
      checkOutput("bvalid held", s_axi_lite_bvalid, 1);
      checkOutput("awready blocked", s_axi_lite_awready, 0);
    end
    @(posedge out_stream_aclk);
    #1 s_axi_lite_bready = 1'b1;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_awready && n < 20);
    checkOutput("queued write accepted", s_axi_lite_awready, 1);
    reg_model[2] = 32'h5A5A_0002;
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_awvalid = 1'b0; s_axi_lite_wvalid = 1'b0;
    @(negedge out_stream_aclk);
    checkOutput("queued bvalid", s_axi_lite_bvalid, 1);
    @(posedge out_stream_aclk);
    #1 s_axi_lite_bready = 1'b0;

    // Held read data; a new read address must wait behind it.
    @(posedge out_stream_aclk);
    #1;
    s_axi_lite_araddr = 8'h04; s_axi_lite_arvalid = 1'b1; s_axi_lite_rready = 1'b0;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_arready && n < 20);
    checkOutput("hold read accepted", s_axi_lite_arready, 1);
    @(posedge out_stream_aclk);
    #1 s_axi_lite_araddr = 8'h08;
    for (int k = 0; k < 3; k++) begin
      @(negedge out_stream_aclk);
      checkOutput("rvalid held", s_axi_lite_rvalid, 1);
      checkOutput("rdata held", s_axi_lite_rdata, 32'hA5A5_0001);
      checkOutput("arready blocked", s_axi_lite_arready, 0);
    end
    @(posedge out_stream_aclk);
    #1 s_axi_lite_rready = 1'b1;
    n = 0;
    do begin @(negedge out_stream_aclk); n++; end
    while (!s_axi_lite_arready && n < 20);
    checkOutput("queued read accepted", s_axi_lite_arready, 1);
    @(posedge out_stream_aclk);
    #1 s_axi_lite_arvalid = 1'b0;
    @(negedge out_stream_aclk);
    checkOutput("queued rdata", s_axi_lite_rdata, 32'h5A5A_0002);
    @(posedge out_stream_aclk);
    #1 s_axi_lite_rready = 1'b0;

    applyStimulus(8'h00, 32'h0000_0055);
    axiRead(8'h00, rd, rr);
    checkOutput("REG0 readback", rd, 32'h0000_0055);
    checkOutput("REG0 rresp", rr, RESP_OKAY);

    // Random stalls straddling the frame boundary, then pulsed tready.
    n = 0;
    while (m_total < FRAME_WORDS - 500 && n < 40000) begin @(posedge out_stream_aclk); n++; end
    checkOutput("reached end of frame 0", (m_total >= FRAME_WORDS - 500), 1);
    ready_mode = 1;
    repeat (3000) @(posedge out_stream_aclk);
    ready_mode = 2;
    repeat (300) @(posedge out_stream_aclk);
    ready_mode = 0;

    n = 0;
    while (!frame1_seen && n < 2000) begin @(posedge out_stream_aclk); n++; end
    checkOutput("frame 1 reached", frame1_seen, 1);
    checkOutput("frame 1 word0 tdata", frame1_data, 32'h5500_0055);
    checkOutput("frame 1 word0 tuser", frame1_user, 1);
    checkOutput("tlast word 149", tlast149, 1);
    checkOutput("tlast word 299", tlast299, 1);

    // Reset in the middle of line 37.
    n = 0;
    while (!(m_line == 37 && m_word == 60) && n < 20000) begin @(posedge out_stream_aclk); n++; end
    checkOutput("reached line 37", m_line, 37);
    @(posedge out_stream_aclk);
    #1;
    axi_reset = 1'b1;
    capture_after_reset = 1;
    repeat (4) @(posedge out_stream_aclk);
    #1 axi_reset = 1'b0;
    n = 0;
    while (!after_reset_seen && n < 20) begin @(posedge out_stream_aclk); n++; end
    checkOutput("post-reset word seen", after_reset_seen, 1);
    checkOutput("post-reset tdata", after_reset_data, 32'h0000_0000);
    checkOutput("post-reset tuser", after_reset_user, 1);

    repeat (300) @(posedge out_stream_aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
